mac_sequencer: RTL and testbench
================================

MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter ACT_AW, default 10, activation memory address width.
REQ-002 Parameter WGT_AW, default 12, weight memory address width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high; shared with the downstream MAC.
REQ-005 start  input  1  request one dot product; sampled only in IDLE.
REQ-006 layer  input  2  layer select: 0/1 = conv (N=25), 2 = FC (N=192), 3 = illegal.
REQ-007 act_base  input  ACT_AW  first activation address.
REQ-008 wgt_base  input  WGT_AW  first weight address.
REQ-009 act_addr  output  ACT_AW  activation read address.
REQ-010 wgt_addr  output  WGT_AW  weight read address.
REQ-011 act_rdata, wgt_rdata  input  16 each  signed read data, valid one cycle after address.
REQ-012 mac_a, mac_b  output  16 each  combinational pass-through of act_rdata, wgt_rdata.
REQ-013 mac_enable  output  1  accumulate strobe to MAC.
REQ-014 mac_layer  output  2  layer latched at start, held through the operation.
REQ-015 mac_out  input  32  signed MAC accumulator.
REQ-016 result  output  32  signed captured dot product.
REQ-017 result_valid / result_ready  output / input  1 each  valid/ready result handshake.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 err  output  1  one-cycle pulse on start with layer==3.

Function
REQ-020 States: IDLE, ISSUE, DRAIN, CAPTURE, HOLD.
- IDLE: start && layer!=3 -> ISSUE; latch layer, bases, N; idx=0.
- start && layer==3: err pulses; stays IDLE.
REQ-021 ISSUE, N cycles: addresses = base+idx, idx increments; after idx N-1 -> DRAIN.
REQ-022 Address arithmetic wraps modulo 2^AW.
REQ-023 mac_enable is the issue flag delayed one cycle; exactly N consecutive high cycles per operation.
REQ-024 DRAIN, one cycle (last enable cycle) -> CAPTURE.
REQ-025 CAPTURE, one cycle, mac_enable low: result <= mac_out at its closing edge (same edge the MAC auto-clears); -> HOLD.
REQ-026 HOLD: result_valid=1, result stable; result_ready high -> IDLE.
REQ-027 Latency: result_valid first high N+2 edges after the start-sampling edge (27 conv, 194 FC), independent of result_ready.
REQ-028 start outside IDLE is ignored (not queued); start in the IDLE cycle after a handshake is accepted.
REQ-029 Address outputs hold last value outside ISSUE; mac_enable never high outside ISSUE/DRAIN.

Reset
REQ-030 On reset: state=IDLE, idx=0, act_addr=0, wgt_addr=0, mac_enable=0, mac_layer=0, result=0, result_valid=0, busy=0, err=0.
REQ-031 Reset mid-operation aborts immediately; no partial result is ever presented; MAC is cleared by the shared reset.

Configuration
REQ-032 Macro MAC_SEQ_BIAS_EN defined: extra input bias (32, signed); result <= mac_out + bias at CAPTURE, sum wrapped to 32 bits.
REQ-033 Macro MAC_SEQ_BIAS_EN undefined: no bias port; result <= mac_out.

Structure
REQ-034 Shared package mac_pkg: state enum, layer encodings, N_CONV=25, N_FC=192, LAYER_ILLEGAL=3.
REQ-035 One sub-module, mac_addr_gen: idx counter, base+idx address generation, last-index flag.

Verification
REQ-036 Layer 0; act=1..25 at act_base=0; wgt=2 everywhere -> 25 enables; result=650 after 27 edges.
REQ-037 Layer 2; 192 pairs of (-3, 5) -> result=-2880 after 194 edges; mac_layer=2 throughout.
REQ-038 result_ready low for 10 cycles -> result_valid and result held; start pulses meanwhile ignored; busy=1.
REQ-039 start with layer=3 -> err one cycle; busy, mac_enable stay 0.
REQ-040 Reset asserted on the 10th enable cycle -> all outputs at reset values; the next start gives a correct 650 result.
REQ-041 act_base=1020 (ACT_AW=10), 25 ops -> act_addr wraps 1023->0; MAC_SEQ_BIAS_EN with bias=-650 on the 650 case -> result=0.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared state encoding, layer codes and operation lengths for the MAC sequencer.
package mac_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_CAPTURE,
      ST_HOLD
   } state_e;

   localparam logic [1:0] LAYER_CONV0   = 2'd0;
   localparam logic [1:0] LAYER_CONV1   = 2'd1;
   localparam logic [1:0] LAYER_FC      = 2'd2;
   localparam logic [1:0] LAYER_ILLEGAL = 2'd3;

   localparam int IDX_W = 8;
   localparam logic [IDX_W-1:0] N_CONV = 8'd25;
   localparam logic [IDX_W-1:0] N_FC   = 8'd192;

   // Number of multiply-accumulate steps for a legal layer code.
   function automatic logic [IDX_W-1:0] op_length(input logic [1:0] layer);
      case (layer)
         LAYER_CONV0, LAYER_CONV1: return N_CONV;
         LAYER_FC:                 return N_FC;
         default:                  return '0;
      endcase
   endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Request, memory, MAC and result-handshake signals of the MAC sequencer.
// Defining MAC_SEQ_BIAS_EN adds the signed 32-bit bias input.
interface mac_sequencer_if #(
   parameter int ACT_AW = 10,
   parameter int WGT_AW = 12
);
   logic                 start;
   logic [1:0]           layer;
   logic [ACT_AW-1:0]    act_base;
   logic [WGT_AW-1:0]    wgt_base;
   logic [ACT_AW-1:0]    act_addr;
   logic [WGT_AW-1:0]    wgt_addr;
   logic signed [15:0]   act_rdata;
   logic signed [15:0]   wgt_rdata;
   logic signed [15:0]   mac_a;
   logic signed [15:0]   mac_b;
   logic                 mac_enable;
   logic [1:0]           mac_layer;
   logic signed [31:0]   mac_out;
   logic signed [31:0]   result;
   logic                 result_valid;
   logic                 result_ready;
   logic                 busy;
   logic                 err;
`ifdef MAC_SEQ_BIAS_EN
   logic signed [31:0]   bias;
`endif

   modport slave (
      input  start, layer, act_base, wgt_base, act_rdata, wgt_rdata, mac_out, result_ready,
`ifdef MAC_SEQ_BIAS_EN
      input  bias,
`endif
      output act_addr, wgt_addr, mac_a, mac_b, mac_enable, mac_layer,
             result, result_valid, busy, err
   );

   modport master (
      output start, layer, act_base, wgt_base, act_rdata, wgt_rdata, mac_out, result_ready,
`ifdef MAC_SEQ_BIAS_EN
      output bias,
`endif
      input  act_addr, wgt_addr, mac_a, mac_b, mac_enable, mac_layer,
             result, result_valid, busy, err
   );

endinterface

// File: rtl/mac_addr_gen.sv
// Index counter and base+index address generator for activation and weight reads.
// Addresses are registered so they hold their last value between operations.
module mac_addr_gen
   import mac_pkg::*;
#(
   parameter int ACT_AW = 10,
   parameter int WGT_AW = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              advance,
   input  logic [IDX_W-1:0]  length,
   input  logic [ACT_AW-1:0] act_base,
   input  logic [WGT_AW-1:0] wgt_base,
   output logic [ACT_AW-1:0] act_addr,
   output logic [WGT_AW-1:0] wgt_addr,
   output logic              last
);

   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [IDX_W-1:0]  length_q, length_d;
   logic [ACT_AW-1:0] act_base_q, act_base_d;
   logic [WGT_AW-1:0] wgt_base_q, wgt_base_d;
   logic [ACT_AW-1:0] act_addr_q, act_addr_d;
   logic [WGT_AW-1:0] wgt_addr_q, wgt_addr_d;

   assign last     = (idx_q == length_q - 1'b1);
   assign act_addr = act_addr_q;
   assign wgt_addr = wgt_addr_q;

   // Sums are truncated to the address width, so reads wrap around memory.
   always_comb begin
      idx_d      = idx_q;
      length_d   = length_q;
      act_base_d = act_base_q;
      wgt_base_d = wgt_base_q;
      act_addr_d = act_addr_q;
      wgt_addr_d = wgt_addr_q;
      if (load) begin
         idx_d      = '0;
         length_d   = length;
         act_base_d = act_base;
         wgt_base_d = wgt_base;
         act_addr_d = act_base;
         wgt_addr_d = wgt_base;
      end else if (advance && !last) begin
         idx_d      = idx_q + 1'b1;
         act_addr_d = act_base_q + ACT_AW'(idx_d);
         wgt_addr_d = wgt_base_q + WGT_AW'(idx_d);
      end else if (advance) begin
         idx_d      = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q      <= '0;
         length_q   <= '0;
         act_base_q <= '0;
         wgt_base_q <= '0;
         act_addr_q <= '0;
         wgt_addr_q <= '0;
      end else begin
         idx_q      <= idx_d;
         length_q   <= length_d;
         act_base_q <= act_base_d;
         wgt_base_q <= wgt_base_d;
         act_addr_q <= act_addr_d;
         wgt_addr_q <= wgt_addr_d;
      end
   end

endmodule

// File: rtl/mac_sequencer.sv
// Sequences one dot product through an external MAC: issue reads, drain, capture, hold.
// Defining MAC_SEQ_BIAS_EN adds a signed bias to the captured result.
module mac_sequencer
   import mac_pkg::*;
#(
   parameter int ACT_AW = 10,
   parameter int WGT_AW = 12
) (
   input logic            clk,
   input logic            reset,
   mac_sequencer_if.slave bus
);

   state_e             state_q, state_d;
   logic               mac_enable_q, mac_enable_d;
   logic [1:0]         mac_layer_q, mac_layer_d;
   logic signed [31:0] result_q, result_d;
   logic               err_q, err_d;
   logic               accept;
   logic               illegal;
   logic               last;

   assign accept  = (state_q == ST_IDLE) && bus.start && (bus.layer != LAYER_ILLEGAL);
   assign illegal = (state_q == ST_IDLE) && bus.start && (bus.layer == LAYER_ILLEGAL);

   mac_addr_gen #(
      .ACT_AW (ACT_AW),
      .WGT_AW (WGT_AW)
   ) u_addr_gen (
      .clk      (clk),
      .reset    (reset),
      .load     (accept),
      .advance  (state_q == ST_ISSUE),
      .length   (op_length(bus.layer)),
      .act_base (bus.act_base),
      .wgt_base (bus.wgt_base),
      .act_addr (bus.act_addr),
      .wgt_addr (bus.wgt_addr),
      .last     (last)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (accept) state_d = ST_ISSUE;
         ST_ISSUE:   if (last) state_d = ST_DRAIN;
         ST_DRAIN:   state_d = ST_CAPTURE;
         ST_CAPTURE: state_d = ST_HOLD;
         ST_HOLD:    if (bus.result_ready) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Read data lags its address by one cycle, so the enable lags the issue state.
   // The MAC clears itself on the capture edge, the same edge that samples mac_out.
   always_comb begin
      bus.busy         = (state_q != ST_IDLE);
      bus.result_valid = (state_q == ST_HOLD);
      mac_enable_d     = (state_q == ST_ISSUE);
      err_d            = illegal;
      mac_layer_d      = accept ? bus.layer : mac_layer_q;
      result_d         = result_q;
      if (state_q == ST_CAPTURE) begin
`ifdef MAC_SEQ_BIAS_EN
         result_d = bus.mac_out + bus.bias;
`else
         result_d = bus.mac_out;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mac_enable_q <= 1'b0;
         mac_layer_q  <= '0;
         result_q     <= '0;
         err_q        <= 1'b0;
      end else begin
         mac_enable_q <= mac_enable_d;
         mac_layer_q  <= mac_layer_d;
         result_q     <= result_d;
         err_q        <= err_d;
      end
   end

   assign bus.mac_a      = bus.act_rdata;
   assign bus.mac_b      = bus.wgt_rdata;
   assign bus.mac_enable = mac_enable_q;
   assign bus.mac_layer  = mac_layer_q;
   assign bus.result     = result_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer with memory and auto-clearing MAC models and a result scoreboard.
// Bias scenarios are compiled in when MAC_SEQ_BIAS_EN is defined.
module tb_mac_sequencer;

   localparam int ACT_AW = 10;
   localparam int WGT_AW = 12;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   bit   saw_wrap;

   logic signed [31:0] exp_q [$];
   logic signed [15:0] act_mem [1024];
   logic signed [15:0] wgt_mem [4096];
   logic signed [31:0] acc;
   logic               en_d;
`ifdef MAC_SEQ_BIAS_EN
   int bias_val = 0;
`endif

   mac_sequencer_if #(.ACT_AW(ACT_AW), .WGT_AW(WGT_AW)) bus ();

   mac_sequencer #(.ACT_AW(ACT_AW), .WGT_AW(WGT_AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Synchronous memories: data appears one cycle after the address.
   always @(posedge clk) begin
      bus.act_rdata <= act_mem[bus.act_addr];
      bus.wgt_rdata <= wgt_mem[bus.wgt_addr];
   end

   // MAC accumulates on enable and clears on the first idle edge after a burst.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         acc  <= '0;
         en_d <= 1'b0;
      end else begin
         en_d <= bus.mac_enable;
         if (bus.mac_enable) acc <= acc + bus.mac_a * bus.mac_b;
         else if (en_d)      acc <= '0;
      end
   end
   assign bus.mac_out = acc;

   function automatic logic signed [31:0] model_dot(input int n, input int abase, input int wbase);
      int sum = 0;
      for (int i = 0; i < n; i++)
         sum = sum + act_mem[(abase + i) % 1024] * wgt_mem[(wbase + i) % 4096];
      return sum;
   endfunction

   task automatic run_op(input string name, input logic [1:0] layer, input int abase,
                         input int wbase, input int hold_cycles, input bit poke_start);
      int n, k, en_cnt, addr_bad, layer_bad, busy_bad, hold_bad, ka;
      logic signed [31:0] expv, popped;
      logic [ACT_AW-1:0] prev_addr;
      n = (layer == 2'd2) ? 192 : 25;
      expv = model_dot(n, abase, wbase);
`ifdef MAC_SEQ_BIAS_EN
      expv = expv + bias_val;
      bus.bias = bias_val;
`endif
      exp_q.push_back(expv);
      bus.start    = 1'b1;
      bus.layer    = layer;
      bus.act_base = ACT_AW'(abase);
      bus.wgt_base = WGT_AW'(wbase);
      @(posedge clk); #1;
      bus.start = 1'b0;
      k = 0; en_cnt = 0; addr_bad = 0; layer_bad = 0; busy_bad = 0; hold_bad = 0;
      saw_wrap  = 1'b0;
      prev_addr = bus.act_addr;
      while (bus.result_valid !== 1'b1 && k < 400) begin
         ka = (k < n) ? k : n - 1;
         if (bus.act_addr !== ACT_AW'(abase + ka) || bus.wgt_addr !== WGT_AW'(wbase + ka))
            addr_bad++;
         if (k > 0 && prev_addr == 10'd1023 && bus.act_addr == 10'd0) saw_wrap = 1'b1;
         prev_addr = bus.act_addr;
         if (bus.mac_enable === 1'b1) en_cnt++;
         if (bus.mac_layer !== layer) layer_bad++;
         if (bus.busy !== 1'b1) busy_bad++;
         @(posedge clk); #1;
         k++;
      end
      checks++;
      if (k != n + 2) begin
         errors++;
         $display("[TB] FAIL %s latency: got %0d edges, expected %0d", name, k, n + 2);
      end
      checks++;
      if (en_cnt != n) begin
         errors++;
         $display("[TB] FAIL %s enable_count: got %0d, expected %0d", name, en_cnt, n);
      end
      checks++;
      if (addr_bad != 0) begin
         errors++;
         $display("[TB] FAIL %s addresses: got %0d bad cycles, expected 0", name, addr_bad);
      end
      checks++;
      if (layer_bad != 0 || busy_bad != 0) begin
         errors++;
         $display("[TB] FAIL %s layer_busy: got %0d/%0d bad cycles, expected 0/0",
                  name, layer_bad, busy_bad);
      end
      popped = (exp_q.size() > 0) ? exp_q.pop_front() : 32'sd0;
      checks++;
      if (bus.result_valid !== 1'b1 || bus.result !== popped) begin
         errors++;
         $display("[TB] FAIL %s result: got %0d (valid %b), expected %0d (valid 1)",
                  name, bus.result, bus.result_valid, popped);
         bus.result_ready = 1'b1;
         @(posedge clk); #1;
         bus.result_ready = 1'b0;
         return;
      end
      for (int i = 0; i < hold_cycles; i++) begin
         if (poke_start) begin
            bus.start = (i % 3 == 0);
            bus.layer = 2'd0;
         end
         @(posedge clk); #1;
         if (bus.result_valid !== 1'b1 || bus.result !== popped || bus.busy !== 1'b1) hold_bad++;
      end
      bus.start = 1'b0;
      if (hold_cycles > 0) begin
         checks++;
         if (hold_bad != 0) begin
            errors++;
            $display("[TB] FAIL %s hold: got %0d unstable cycles, expected 0", name, hold_bad);
         end
      end
      bus.result_ready = 1'b1;
      @(posedge clk); #1;
      bus.result_ready = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s handshake: got busy %b valid %b, expected 0 0",
                  name, bus.busy, bus.result_valid);
      end
      if (poke_start) begin
         @(posedge clk); #1;
         checks++;
         if (bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s queued_start: got busy %b, expected 0", name, bus.busy);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.act_addr !== '0 || bus.wgt_addr !== '0) begin
         errors++;
         $display("[TB] FAIL reset_addr: got %0d/%0d, expected 0/0", bus.act_addr, bus.wgt_addr);
      end
      checks++;
      if (bus.mac_enable !== 1'b0 || bus.mac_layer !== 2'd0) begin
         errors++;
         $display("[TB] FAIL reset_mac: got enable %b layer %0d, expected 0 0",
                  bus.mac_enable, bus.mac_layer);
      end
      checks++;
      if (bus.result !== '0 || bus.result_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_result: got %0d valid %b, expected 0 0",
                  bus.result, bus.result_valid);
      end
      checks++;
      if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_status: got busy %b err %b, expected 0 0", bus.busy, bus.err);
      end
      reset = 1'b0;
   endtask

   task automatic test_conv();
      run_op("conv", 2'd0, 0, 0, 0, 1'b0);
   endtask

   task automatic test_fc();
      run_op("fc", 2'd2, 200, 2000, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_op("b2b_first", 2'd1, 0, 0, 0, 1'b0);
      run_op("b2b_second", 2'd2, 200, 2000, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      run_op("backpressure", 2'd0, 0, 0, 10, 1'b1);
   endtask

   task automatic test_illegal();
      bus.start = 1'b1;
      bus.layer = 2'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      checks++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.mac_enable !== 1'b0) begin
         errors++;
         $display("[TB] FAIL illegal_pulse: got err %b busy %b enable %b, expected 1 0 0",
                  bus.err, bus.busy, bus.mac_enable);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.mac_enable !== 1'b0) begin
         errors++;
         $display("[TB] FAIL illegal_after: got err %b busy %b enable %b, expected 0 0 0",
                  bus.err, bus.busy, bus.mac_enable);
      end
   endtask

   task automatic test_reset_mid_op();
      int cnt = 0;
      int k = 0;
      logic [59:0] snap;
      bus.start    = 1'b1;
      bus.layer    = 2'd0;
      bus.act_base = '0;
      bus.wgt_base = '0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      while (cnt < 10 && k < 100) begin
         @(posedge clk); #1;
         k++;
         if (bus.mac_enable === 1'b1) cnt++;
      end
      checks++;
      if (cnt != 10) begin
         errors++;
         $display("[TB] FAIL midreset_reach: got %0d enables, expected 10", cnt);
      end
      reset = 1'b1;
      #1;
      snap = {bus.act_addr, bus.wgt_addr, bus.mac_enable, bus.mac_layer, bus.result,
              bus.result_valid, bus.busy, bus.err};
      checks++;
      if (snap !== '0) begin
         errors++;
         $display("[TB] FAIL midreset_outputs: got %h, expected 0", snap);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      run_op("after_reset", 2'd0, 0, 0, 0, 1'b0);
   endtask

   task automatic test_wrap();
      run_op("wrap", 2'd0, 1020, 100, 0, 1'b0);
      checks++;
      if (saw_wrap !== 1'b1) begin
         errors++;
         $display("[TB] FAIL wrap_addr: got wrap %b, expected 1", saw_wrap);
      end
   endtask

`ifdef MAC_SEQ_BIAS_EN
   task automatic test_bias();
      bias_val = -650;
      run_op("bias", 2'd0, 0, 0, 0, 1'b0);
      bias_val = 0;
   endtask
`endif

   initial begin
      for (int i = 0; i < 1024; i++) act_mem[i] = '0;
      for (int i = 0; i < 25; i++)   act_mem[i] = 16'(i + 1);
      for (int i = 0; i < 192; i++)  act_mem[200 + i] = -16'sd3;
      act_mem[1020] = 16'sd7;
      act_mem[1021] = -16'sd8;
      act_mem[1022] = 16'sd9;
      act_mem[1023] = -16'sd10;
      for (int i = 0; i < 4096; i++) wgt_mem[i] = 16'sd2;
      for (int i = 0; i < 192; i++)  wgt_mem[2000 + i] = 16'sd5;
      bus.start        = 1'b0;
      bus.layer        = 2'd0;
      bus.act_base     = '0;
      bus.wgt_base     = '0;
      bus.result_ready = 1'b0;
`ifdef MAC_SEQ_BIAS_EN
      bus.bias = '0;
`endif
      test_reset();
      @(posedge clk); #1;
      test_conv();
      test_fc();
      test_back_to_back();
      test_backpressure();
      test_illegal();
      test_reset_mid_op();
      test_wrap();
`ifdef MAC_SEQ_BIAS_EN
      test_bias();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no completion by 200000, expected earlier finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
